music_sequencer: RTL and testbench
==================================

Name: music_sequencer

Overview:
- Upstream note sequencer for audio_multichannel. Plays a short score from a small internal score RAM and drives one channel's enable, frequency word and volume, replacing the hand-written note sequences used in benches.
- Host writes the score, pulses start_i, and the block steps through entries on a fixed tempo grid.
- Outputs connect directly to the chN_en_i, chN_freq_i and chN_volume_i inputs of audio_multichannel.

Parameters:
- STEP_CYCLES, 3125000, clk cycles per tempo step (0.25 s at 12.5 MHz).
- SCORE_DEPTH, 32, score RAM entries (power of 2).
- GAP_CYCLES, 312500, articulation gap length. Used only with MUSIC_SEQ_GAP_EN. Must be < STEP_CYCLES.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- wr_en_i  in  1  score RAM write strobe
- wr_addr_i  in  $clog2(SCORE_DEPTH)  write address
- wr_data_i  in  29  entry {rest[28], volume[27:20], len[19:16], freq[15:0]}
- start_i  in  1  start playback from entry 0 (pulse)
- stop_i  in  1  abort playback (pulse)
- loop_i  in  1  at end of score, restart from entry 0
- ch_en_o  out  1  channel enable
- ch_freq_o  out  16  phase-increment frequency word
- ch_volume_o  out  8  channel volume
- busy_o  out  1  playback in progress
- done_o  out  1  one-cycle pulse on natural completion
- step_idx_o  out  $clog2(SCORE_DEPTH)  index of the entry currently playing

Behaviour:
- Reset (async, rstn=0): all outputs 0, FSM in IDLE, all counters 0. Reset mid-playback aborts immediately. done_o does not pulse.
- Score RAM: asynchronous read, synchronous write. Writes are accepted in any state. An entry is latched when loaded, so a write to the playing entry takes effect only on its next load.
- Entry with len==0 is the END marker. Duration of a normal entry is exactly len*STEP_CYCLES clk cycles (len 1..15).
- FSM states: IDLE, NOTE, GAP (GAP exists only with the feature enabled).
- IDLE, start_i=1, stop_i=0: load entry 0.
  - If entry 0 is END: stay IDLE and pulse done_o next cycle.
  - Otherwise: go to NOTE. Outputs take entry 0 values at that same edge, so latency from start sample to ch_en_o is 1 cycle. busy_o goes to 1.
- NOTE:
  - ch_en_o = ~rest; ch_volume_o = entry volume.
  - ch_freq_o = entry freq for non-rest entries. During a rest, ch_freq_o holds its previous value.
  - Step timer counts 0..STEP_CYCLES-1; note counter counts steps up to len.
  - On the last cycle of the note, the next entry (idx+1) is loaded at the following edge, with no idle cycle between notes.
- End of score: reached when the next entry is END, or when idx == SCORE_DEPTH-1 finishes (no wrap).
  - loop_i=1 at that cycle: load entry 0 seamlessly.
  - loop_i=0: go to IDLE. ch_en_o=0, busy_o=0 and done_o=1 for one cycle, all at the same edge. ch_freq_o and ch_volume_o hold.
- stop_i in NOTE or GAP: next edge goes to IDLE with ch_en_o=0 and busy_o=0. done_o does not pulse.
- Simultaneous events:
  - stop_i and start_i together: stop wins, remain or go to IDLE.
  - start_i while busy: ignored.
- Timers restart from 0 on every entry load.
- step_idx_o updates on the same edge as the entry load.

Optional Feature:
- Macro MUSIC_SEQ_GAP_EN.
- Defined: the final GAP_CYCLES cycles of every non-rest note are spent in state GAP with ch_en_o=0 while ch_freq_o holds. Total note duration is unchanged.
- Undefined: no GAP state, and ch_en_o stays continuously high across consecutive non-rest notes.

Decomposition:
- Package music_seq_pkg holds:
  - score_entry_t: packed struct with fields rest, volume, len, freq.
  - seq_state_t: enum with IDLE, NOTE, GAP.
  - SEQ_ENTRY_W = 29.
  - Note constants G4_FREQ=16'd4208, DS4_FREQ=16'd3339, AS4_FREQ=16'd5005.
- One sub-module, seq_step_timer: step tick counter with clear input and tick output.

Test Plan (STEP_CYCLES=10, GAP_CYCLES=3, SCORE_DEPTH=8):
- Reset asserted mid-note: all outputs 0 on the same cycle, no done_o; after release, stays IDLE until start_i.
- Score {G4 len2, DS4 len1, END}, start at cycle 0: ch_en_o=1 over cycles 1..30; ch_freq_o=4208 for cycles 1..20 and 3339 for cycles 21..30; cycle 31 has ch_en_o=0, busy_o=0, done_o=1 for one cycle.
- Score {G4 len1, rest len1, AS4 len1, END}: ch_en_o low for cycles 11..20 with ch_freq_o=4208 held; cycles 21..30 give freq 5005.
- Score with loop_i=1: entry 0 reloads on the cycle after the last note with no enable drop. Clearing loop_i stops playback after the current pass and pulses done_o.
- stop_i at cycle 5 of a note: ch_en_o=0 and busy_o=0 at cycle 6, done_o stays 0. Asserting start_i and stop_i together from IDLE leaves the block in IDLE.
- MUSIC_SEQ_GAP_EN defined, two G4 len1 notes: ch_en_o high on cycles 1..7, low on 8..10, high on 11..17, low on 18..20; done_o pulses at cycle 21.

Source files
------------

// File: rtl/music_seq_pkg.sv
// Shared types and constants for the music sequencer.
package music_seq_pkg;

    localparam int unsigned SEQ_ENTRY_W = 29;

    // Score entry layout: {rest, volume, len, freq}; len == 0 marks END.
    typedef struct packed {
        logic        rest;
        logic [7:0]  volume;
        logic [3:0]  len;
        logic [15:0] freq;
    } score_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        NOTE,
        GAP
    } seq_state_t;

    localparam logic [15:0] G4_FREQ  = 16'd4208;
    localparam logic [15:0] DS4_FREQ = 16'd3339;
    localparam logic [15:0] AS4_FREQ = 16'd5005;

endpackage

// File: rtl/music_sequencer_seq_step_timer.sv
// Tempo step timer: counts 0..STEP_CYCLES-1 and flags the last cycle of each step.
// With MUSIC_SEQ_GAP_EN defined it also flags the cycle before the articulation gap.
module seq_step_timer #(
    parameter int unsigned STEP_CYCLES = 3125000,
    parameter int unsigned GAP_CYCLES  = 312500
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear_i,
`ifdef MUSIC_SEQ_GAP_EN
    output logic gap_o,
`endif
    output logic tick_o
);

    localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [CntW-1:0] cnt_q;

    assign tick_o = (cnt_q == CntW'(STEP_CYCLES - 1));
`ifdef MUSIC_SEQ_GAP_EN
    // Last cycle before the final GAP_CYCLES cycles of a step.
    assign gap_o  = (cnt_q == CntW'(STEP_CYCLES - 1 - GAP_CYCLES));
`endif

    // Step counter; wraps on tick, forced to zero by clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clear_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/music_sequencer.sv
// Score-RAM driven note sequencer feeding one audio_multichannel channel.
// Optional articulation gap: define MUSIC_SEQ_GAP_EN.
module music_sequencer
    import music_seq_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 3125000,
    parameter int unsigned SCORE_DEPTH = 32,
    parameter int unsigned GAP_CYCLES  = 312500
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           wr_en_i,
    input  logic [$clog2(SCORE_DEPTH)-1:0] wr_addr_i,
    input  logic [SEQ_ENTRY_W-1:0]         wr_data_i,
    input  logic                           start_i,
    input  logic                           stop_i,
    input  logic                           loop_i,
    output logic                           ch_en_o,
    output logic [15:0]                    ch_freq_o,
    output logic [7:0]                     ch_volume_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [$clog2(SCORE_DEPTH)-1:0] step_idx_o
);

    localparam int unsigned IdxW = $clog2(SCORE_DEPTH);

    score_entry_t    ram [SCORE_DEPTH];
    seq_state_t      state_q, state_d;
    score_entry_t    entry_q, entry_d;
    logic [IdxW-1:0] idx_q, idx_d, idx_inc, load_idx;
    logic [3:0]      steps_q, steps_d;
    logic            en_q, en_d, busy_q, busy_d, done_q, done_d;
    logic [15:0]     freq_q, freq_d;
    logic [7:0]      vol_q, vol_d;
    logic            load, tick, last_step, note_last, last_idx, timer_clear;
`ifdef MUSIC_SEQ_GAP_EN
    logic            gap_start;
`endif

    assign idx_inc   = idx_q + 1'b1;
    assign last_idx  = (idx_q == IdxW'(SCORE_DEPTH - 1));
    assign last_step = (steps_q == entry_q.len - 4'd1);
    assign note_last = tick && last_step;

    // Timers restart on every entry load and stay cleared while idle.
    assign timer_clear = load || (state_d == IDLE);

    seq_step_timer #(
        .STEP_CYCLES (STEP_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear_i (timer_clear),
`ifdef MUSIC_SEQ_GAP_EN
        .gap_o   (gap_start),
`endif
        .tick_o  (tick)
    );

    // Score RAM write port; reads are asynchronous.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            ram[wr_addr_i] <= score_entry_t'(wr_data_i);
        end
    end

    // Next-state, entry loading and registered output values.
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        idx_d    = idx_q;
        steps_d  = steps_q;
        en_d     = en_q;
        freq_d   = freq_q;
        vol_d    = vol_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load     = 1'b0;
        load_idx = '0;
        unique case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    if (ram[0].len == 4'd0) begin
                        done_d = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            NOTE, GAP: begin
                if (stop_i) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    steps_d = '0;
                end else if (note_last) begin
                    if (!last_idx && ram[idx_inc].len != 4'd0) begin
                        load     = 1'b1;
                        load_idx = idx_inc;
                    end else if (loop_i && ram[0].len != 4'd0) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        steps_d = '0;
                    end
                end else begin
                    if (tick) begin
                        steps_d = steps_q + 4'd1;
                    end
`ifdef MUSIC_SEQ_GAP_EN
                    if (state_q == NOTE && !entry_q.rest && last_step && gap_start) begin
                        state_d = GAP;
                        en_d    = 1'b0;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        // A rest keeps the previous frequency word on the channel.
        if (load) begin
            state_d = NOTE;
            entry_d = ram[load_idx];
            idx_d   = load_idx;
            steps_d = '0;
            busy_d  = 1'b1;
            en_d    = ~ram[load_idx].rest;
            vol_d   = ram[load_idx].volume;
            if (!ram[load_idx].rest) begin
                freq_d = ram[load_idx].freq;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            entry_q <= '0;
            idx_q   <= '0;
            steps_q <= '0;
            en_q    <= 1'b0;
            freq_q  <= '0;
            vol_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            idx_q   <= idx_d;
            steps_q <= steps_d;
            en_q    <= en_d;
            freq_q  <= freq_d;
            vol_q   <= vol_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ch_en_o     = en_q;
    assign ch_freq_o   = freq_q;
    assign ch_volume_o = vol_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign step_idx_o  = idx_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer: directed score scenarios plus randomized
// playback, checked every cycle against a remaining-time behavioural model.
module tb_music_sequencer;
    import music_seq_pkg::*;

    localparam int unsigned STEP  = 10;
    localparam int unsigned GAP   = 3;
    localparam int unsigned DEPTH = 8;
`ifdef MUSIC_SEQ_GAP_EN
    localparam bit GapOn = 1'b1;
`else
    localparam bit GapOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [2:0]  wr_addr_i = '0;
    logic [28:0] wr_data_i = '0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        loop_i = 1'b0;
    logic        ch_en_o;
    logic [15:0] ch_freq_o;
    logic [7:0]  ch_volume_o;
    logic        busy_o;
    logic        done_o;
    logic [2:0]  step_idx_o;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    logic [28:0] m_ram [DEPTH];
    logic [28:0] m_cur;
    bit          m_play;
    int          m_idx;
    int          m_rem;
    logic        m_en, m_busy, m_done;
    logic [15:0] m_freq;
    logic [7:0]  m_vol;

    music_sequencer #(
        .STEP_CYCLES (STEP),
        .SCORE_DEPTH (DEPTH),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .loop_i      (loop_i),
        .ch_en_o     (ch_en_o),
        .ch_freq_o   (ch_freq_o),
        .ch_volume_o (ch_volume_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .step_idx_o  (step_idx_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [28:0] ent(input bit rest, input logic [7:0] vol,
                                        input logic [3:0] len, input logic [15:0] f);
        return {rest, vol, len, f};
    endfunction

    function automatic logic [28:0] rnd_entry(input int min_len);
        return ent($urandom_range(0, 3) == 0, 8'($urandom), 4'($urandom_range(min_len, 3)),
                   16'($urandom));
    endfunction

    task automatic m_reset();
        m_play = 1'b0;
        m_idx  = 0;
        m_rem  = 0;
        m_cur  = '0;
        m_en   = 1'b0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_freq = '0;
        m_vol  = '0;
    endtask

    task automatic m_load(input int i);
        m_cur  = m_ram[i];
        m_idx  = i;
        m_rem  = int'(m_cur[19:16]) * STEP;
        m_play = 1'b1;
        m_busy = 1'b1;
        m_en   = !m_cur[28];
        m_vol  = m_cur[27:20];
        if (!m_cur[28]) m_freq = m_cur[15:0];
    endtask

    task automatic m_halt();
        m_play = 1'b0;
        m_en   = 1'b0;
        m_busy = 1'b0;
    endtask

    // One clock edge of the reference: m_rem is cycles left in the current note.
    task automatic model_edge();
        m_done = 1'b0;
        if (!m_play) begin
            if (start_i && !stop_i) begin
                if (m_ram[0][19:16] == 4'd0) m_done = 1'b1;
                else m_load(0);
            end
        end else if (stop_i) begin
            m_halt();
        end else if (m_rem == 1) begin
            if (m_idx < int'(DEPTH) - 1 && m_ram[m_idx + 1][19:16] != 4'd0) m_load(m_idx + 1);
            else if (loop_i && m_ram[0][19:16] != 4'd0) m_load(0);
            else begin
                m_halt();
                m_done = 1'b1;
            end
        end else begin
            m_rem--;
            m_en = !m_cur[28] && !(GapOn && m_rem <= int'(GAP));
        end
    endtask

    task automatic compare();
        check_eq("ch_en", 32'(ch_en_o), 32'(m_en));
        check_eq("ch_freq", 32'(ch_freq_o), 32'(m_freq));
        check_eq("ch_volume", 32'(ch_volume_o), 32'(m_vol));
        check_eq("busy", 32'(busy_o), 32'(m_busy));
        check_eq("done", 32'(done_o), 32'(m_done));
        if (m_busy) check_eq("step_idx", 32'(step_idx_o), 32'(m_idx));
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (!rstn) m_reset();
            else model_edge();
            if (wr_en_i) m_ram[wr_addr_i] = wr_data_i;
            #1;
            compare();
        end
    endtask

    task automatic write_entry(input int addr, input logic [28:0] data);
        wr_en_i   = 1'b1;
        wr_addr_i = 3'(addr);
        wr_data_i = data;
        tick(1);
        wr_en_i   = 1'b0;
    endtask

    initial begin
        m_reset();
        for (int a = 0; a < int'(DEPTH); a++) m_ram[a] = '0;

        // Reset state.
        tick(3);
        check_eq("rst_en", 32'(ch_en_o), 0);
        check_eq("rst_busy", 32'(busy_o), 0);
        rstn = 1'b1;
        for (int a = 0; a < int'(DEPTH); a++) write_entry(a, '0);
        tick(2);

        // Score {G4 len2, DS4 len1, END}.
        write_entry(0, ent(1'b0, 8'h80, 4'd2, G4_FREQ));
        write_entry(1, ent(1'b0, 8'h40, 4'd1, DS4_FREQ));
        write_entry(2, '0);
        start_i = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            tick(1);
            start_i = 1'b0;
            if (c == 1 || c == 20) check_eq("a_freq_g4", 32'(ch_freq_o), 32'(G4_FREQ));
            if (c == 21 || c == 30) check_eq("a_freq_ds4", 32'(ch_freq_o), 32'(DS4_FREQ));
            if (c == 31) begin
                check_eq("a_done", 32'(done_o), 1);
                check_eq("a_en_off", 32'(ch_en_o), 0);
                check_eq("a_busy_off", 32'(busy_o), 0);
            end
            if (c == 32) check_eq("a_done_once", 32'(done_o), 0);
`ifndef MUSIC_SEQ_GAP_EN
            if (c == 1 || c == 20 || c == 21 || c == 30) check_eq("a_en_on", 32'(ch_en_o), 1);
`endif
        end

        // Score {G4 len1, rest len1, AS4 len1, END}.
        write_entry(0, ent(1'b0, 8'h80, 4'd1, G4_FREQ));
        write_entry(1, ent(1'b1, 8'h20, 4'd1, 16'h1234));
        write_entry(2, ent(1'b0, 8'h60, 4'd1, AS4_FREQ));
        write_entry(3, '0);
        start_i = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            tick(1);
            start_i = 1'b0;
            if (c == 11 || c == 20) begin
                check_eq("b_rest_en", 32'(ch_en_o), 0);
                check_eq("b_rest_freq", 32'(ch_freq_o), 32'(G4_FREQ));
            end
            if (c == 21 || c == 30) check_eq("b_freq_as4", 32'(ch_freq_o), 32'(AS4_FREQ));
            if (c == 31) check_eq("b_done", 32'(done_o), 1);
        end

        // Looping {G4 len1, AS4 len1, END}; loop dropped during the second pass.
        write_entry(1, ent(1'b0, 8'h60, 4'd1, AS4_FREQ));
        write_entry(2, '0);
        loop_i  = 1'b1;
        start_i = 1'b1;
        for (int c = 1; c <= 43; c++) begin
            tick(1);
            start_i = 1'b0;
            if (c == 21) begin
                check_eq("c_reload_idx", 32'(step_idx_o), 0);
                check_eq("c_reload_freq", 32'(ch_freq_o), 32'(G4_FREQ));
                check_eq("c_reload_busy", 32'(busy_o), 1);
                check_eq("c_no_done", 32'(done_o), 0);
`ifndef MUSIC_SEQ_GAP_EN
                check_eq("c_reload_en", 32'(ch_en_o), 1);
`endif
            end
            if (c == 25) loop_i = 1'b0;
            if (c == 41) check_eq("c_done", 32'(done_o), 1);
        end

        // Stop mid-note, then start and stop together from idle.
        start_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick(1);
            start_i = 1'b0;
        end
        stop_i = 1'b1;
        tick(1);
        stop_i = 1'b0;
        check_eq("d_stop_en", 32'(ch_en_o), 0);
        check_eq("d_stop_busy", 32'(busy_o), 0);
        check_eq("d_stop_done", 32'(done_o), 0);
        start_i = 1'b1;
        stop_i  = 1'b1;
        tick(1);
        start_i = 1'b0;
        stop_i  = 1'b0;
        check_eq("d_both_busy", 32'(busy_o), 0);
        tick(3);

`ifdef MUSIC_SEQ_GAP_EN
        // Articulation gap across two G4 notes.
        write_entry(1, ent(1'b0, 8'h80, 4'd1, G4_FREQ));
        start_i = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick(1);
            start_i = 1'b0;
            if (c <= 20)
                check_eq("e_gap_en", 32'(ch_en_o), 32'((c <= 7) || (c >= 11 && c <= 17)));
            if (c == 21) check_eq("e_done", 32'(done_o), 1);
        end
`endif

        // Reset asserted mid-note.
        write_entry(0, ent(1'b0, 8'h80, 4'd2, G4_FREQ));
        write_entry(1, ent(1'b0, 8'h40, 4'd1, DS4_FREQ));
        write_entry(2, '0);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        tick(7);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("f_rst_en", 32'(ch_en_o), 0);
        check_eq("f_rst_freq", 32'(ch_freq_o), 0);
        check_eq("f_rst_vol", 32'(ch_volume_o), 0);
        check_eq("f_rst_busy", 32'(busy_o), 0);
        check_eq("f_rst_done", 32'(done_o), 0);
        check_eq("f_rst_idx", 32'(step_idx_o), 0);
        m_reset();
        tick(2);
        rstn = 1'b1;
        tick(25);

        // Randomized scores, loop, stray start/stop pulses and live score writes.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, DEPTH));
            for (int a = 0; a < int'(DEPTH); a++) write_entry(a, (a < n) ? rnd_entry(1) : '0);
            loop_i  = 1'($urandom_range(0, 1));
            start_i = 1'b1;
            for (int c = 0; c < 300; c++) begin
                tick(1);
                start_i   = ($urandom_range(0, 29) == 0);
                stop_i    = ($urandom_range(0, 79) == 0);
                wr_en_i   = ($urandom_range(0, 19) == 0);
                wr_addr_i = 3'($urandom_range(0, DEPTH - 1));
                wr_data_i = rnd_entry(0);
                if (c == 150) loop_i = 1'b0;
            end
            start_i = 1'b0;
            stop_i  = 1'b0;
            wr_en_i = 1'b0;
            loop_i  = 1'b0;
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
